// File: rtl/xor_seq_pkg.sv
// Shared constants and state encoding for the byte-serial XOR sequencer.
package xor_seq_pkg;
  localparam int BYTE_W = 8;
  localparam int IMM_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/bit8_xor.sv
// Existing 8-bit XOR logic slice shared by the byte-serial sequencer.
module bit8_xor
  import xor_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic [BYTE_W-1:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/xor32_seq_ctrl.sv
// Byte-serial XOR/XORI: one 8-bit slice stepped LSB first over NUM_BYTES cycles.
module xor32_seq_ctrl
  import xor_seq_pkg::*;
#(
  parameter  int NUM_BYTES = 4,
  localparam int W         = BYTE_W * NUM_BYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             imm_mode,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [IMM_W-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result,
  output logic             zero
);
  localparam int            IW   = $clog2(NUM_BYTES);
  localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

  state_t                           state, state_nxt;
  logic [IW-1:0]                    idx;
  logic [NUM_BYTES-1:0][BYTE_W-1:0] a_q, b_q, res_q, res_nxt;
  logic [BYTE_W-1:0]                slice_y;
  logic                             accept, last;

  bit8_xor u_slice (
    .a (a_q[idx]),
    .b (b_q[idx]),
    .y (slice_y)
  );

  always_comb begin
    accept       = start && (state == ST_IDLE || state == ST_DONE);
    last         = (idx == LAST);
    res_nxt      = res_q;
    res_nxt[idx] = slice_y;
    state_nxt    = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // busy/done are flopped from the next state so outputs stay purely registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_RUN);
      done  <= (state_nxt == ST_DONE);
      if (accept) begin
        a_q   <= a;
        b_q   <= imm_mode ? W'(imm) : b;
        idx   <= '0;
        res_q <= '0;
      end else if (state == ST_RUN) begin
        res_q <= res_nxt;
        idx   <= last ? '0 : idx + IW'(1);
        if (last) zero <= (res_nxt == '0);
      end
    end
  end

  assign result = res_q;
endmodule

// File: tb/tb_xor32_seq_ctrl.sv
// Directed + random bench for xor32_seq_ctrl against a cycles-since-start model.
module tb_xor32_seq_ctrl;
  localparam int N = 4;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         rst, start, imm_mode;
  logic [W-1:0] a, b;
  logic [15:0]  imm;
  logic         busy, done, zero;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  // reference: k = cycles since the accepted start (0 = fresh from reset)
  int           m_k    = 0;
  logic [W-1:0] m_full = '0;
  logic [W-1:0] m_res  = '0;
  logic         m_zero = 1'b0;

  xor32_seq_ctrl #(.NUM_BYTES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .imm_mode(imm_mode),
    .a(a), .b(b), .imm(imm),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] low_bytes(input logic [W-1:0] v, input int nb);
    logic [63:0] mask;
    mask = (nb >= N) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
    return v & mask[W-1:0];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_k = 0; m_res = '0; m_zero = 1'b0;
    end else if (start && !(m_k >= 1 && m_k <= N)) begin
      m_full = a ^ (imm_mode ? W'(imm) : b);
      m_k    = 1;
      m_res  = '0;
    end else if (m_k >= 1 && m_k <= N + 1) begin
      m_k++;
      m_res = low_bytes(m_full, m_k - 1);
      if (m_k == N + 1) m_zero = (m_full == '0);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic im,
                      input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [15:0] ii);
    rst = r; start = s; imm_mode = im; a = aa; b = bb; imm = ii;
    @(posedge clk);
    model_edge();
    #1;
    chk("busy",   W'(busy), W'(m_k >= 1 && m_k <= N));
    chk("done",   W'(done), W'(m_k == N + 1));
    chk("result", result,   m_res);
    chk("zero",   W'(zero), W'(m_zero));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic go(input logic im, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [15:0] ii);
    step(1'b0, 1'b1, im, aa, bb, ii);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imm_mode = 1'b0; a = '0; b = '0; imm = '0;
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    chk("rst_result", result, '0);
    idle(3);
    chk("idle_busy", W'(busy), '0);

    // XOR
    go(1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 16'h0);
    chk("xor_busy_t1", W'(busy), 1);
    idle(4);
    chk("xor_done",   W'(done), 1);
    chk("xor_result", result, 32'hF0F00F0F);
    chk("xor_zero",   W'(zero), 0);
    idle(2);

    // XORI, b ignored
    go(1'b1, 32'h12345678, 32'hFFFFFFFF, 16'h5678);
    idle(4);
    chk("xori_done",   W'(done), 1);
    chk("xori_result", result, 32'h12340000);
    chk("xori_zero",   W'(zero), 0);

    // zero result, then back-to-back start in the DONE cycle
    go(1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 16'h0);
    idle(4);
    chk("zero_done",   W'(done), 1);
    chk("zero_result", result, '0);
    chk("zero_flag",   W'(zero), 1);
    go(1'b0, 32'h1, 32'h0, 16'h0);
    idle(4);
    chk("b2b_done",   W'(done), 1);
    chk("b2b_result", result, 32'h1);
    chk("b2b_zero",   W'(zero), 0);
    idle(1);

    // start during busy is ignored
    go(1'b0, 32'hA5A5A5A5, 32'h0000FFFF, 16'h0);
    idle(1);
    go(1'b0, 32'h11111111, 32'h22222222, 16'h0);
    idle(2);
    chk("ign_done",   W'(done), 1);
    chk("ign_result", result, 32'hA5A55A5A);
    idle(1);

    // reset mid-operation
    go(1'b0, 32'hCAFEBABE, 32'h01234567, 16'h0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    chk("abort_busy",   W'(busy), 0);
    chk("abort_result", result, '0);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("abort_nodone", W'(done), 0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 40) == 0, ($urandom % 3) != 0, 1'($urandom % 2),
           W'($urandom), W'($urandom), 16'($urandom_range(0, 65535)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
